cache_axi_arbiter: RTL and testbench

//  Shares the single AXI3 master port between ICache miss/uncached reads and DCache reads and writebacks.

---
 rtl/cache_axi_arbiter_pkg.sv | 31 +++
 rtl/cache_axi_arbiter_wr.sv | 123 ++++++++++++
 rtl/cache_axi_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared encodings and read-sizing helpers for the cache AXI arbiter.
package cache_axi_arbiter_pkg;

    localparam logic [3:0] AXI_ID_INST = 4'd0;
    localparam logic [3:0] AXI_ID_DATA = 4'd1;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    // Line requests are line-aligned word bursts; others are a single beat of the requested size.
    function automatic logic [31:0] axi_addr(input logic [2:0] typ, input logic [31:0] addr);
        return (typ == RD_TYPE_LINE) ? {addr[31:4], 4'b0000} : addr;
    endfunction

    function automatic logic [7:0] axi_len(input logic [2:0] typ, input int line_words);
        return (typ == RD_TYPE_LINE) ? 8'(line_words - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] axi_size(input logic [2:0] typ);
        return (typ == RD_TYPE_LINE) ? 3'd2 : {1'b0, typ[1:0]};
    endfunction

endpackage

// File: rtl/cache_axi_arbiter_wr.sv
// Single-outstanding AXI write engine: AW/W/B sequencing, beat counter and word selection.
module cache_axi_arbiter_wr
    import cache_axi_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_req_i,
    input  logic [2:0]              wr_type_i,
    input  logic [31:0]             wr_addr_i,
    input  logic [3:0]              wr_wstrb_i,
    input  logic [32*LINE_WORDS-1:0] wr_data_i,
    output logic                    wr_rdy_o,
    output logic [31:0]             awaddr_o,
    output logic [7:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [31:0]             wdata_o,
    output logic [3:0]              wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output wstate_e                 wstate_o,
    output logic [27:0]             wr_line_o
);

    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    wstate_e                       state_q, state_d;
    logic [31:0]                   addr_q, addr_d;
    logic [2:0]                    type_q, type_d;
    logic [3:0]                    wstrb_q, wstrb_d;
    logic [LINE_WORDS-1:0][31:0]   data_q, data_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic                          is_line;

    assign is_line   = (type_q == RD_TYPE_LINE);
    assign awaddr_o  = axi_addr(type_q, addr_q);
    assign awlen_o   = axi_len(type_q, LINE_WORDS);
    assign awsize_o  = axi_size(type_q);
    assign wdata_o   = data_q[cnt_q];
    assign wstrb_o   = is_line ? 4'hf : wstrb_q;
    assign wlast_o   = (8'(cnt_q) == awlen_o);
    assign wstate_o  = state_q;
    assign wr_line_o = addr_q[31:4];

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        type_d    = type_q;
        wstrb_d   = wstrb_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_rdy_o  = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        bready_o  = 1'b0;
        case (state_q)
            W_IDLE: begin
                wr_rdy_o = 1'b1;
                if (wr_req_i) begin
                    state_d   = W_SEND;
                    addr_d    = wr_addr_i;
                    type_d    = wr_type_i;
                    wstrb_d   = wr_wstrb_i;
                    data_d    = wr_data_i;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_SEND: begin
                awvalid_o = !aw_done_q;
                wvalid_o  = !w_done_q;
                if (awvalid_o && awready_i) aw_done_d = 1'b1;
                if (wvalid_o && wready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (wlast_o) w_done_d = 1'b1;
                end
                // AW and the final W beat may complete in either order or together.
                if (aw_done_d && w_done_d) state_d = W_RESP;
            end
            W_RESP: begin
                bready_o = 1'b1;
                if (bvalid_i) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= W_IDLE;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed once the FSM has loaded them.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        type_q  <= type_d;
        wstrb_q <= wstrb_d;
        data_q  <= data_d;
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI3 master between ICache reads and DCache reads/writebacks; DCache wins read arbitration.
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] ID_INST    = AXI_ID_INST,
    parameter logic [3:0] ID_DATA    = AXI_ID_DATA
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_rd_req,
    input  logic [2:0]               i_rd_type,
    input  logic [31:0]              i_rd_addr,
    output logic                     i_rd_rdy,
    output logic                     i_ret_valid,
    output logic                     i_ret_last,
    output logic [31:0]              i_ret_data,
    input  logic                     d_rd_req,
    input  logic [2:0]               d_rd_type,
    input  logic [31:0]              d_rd_addr,
    output logic                     d_rd_rdy,
    output logic                     d_ret_valid,
    output logic                     d_ret_last,
    output logic [31:0]              d_ret_data,
    input  logic                     d_wr_req,
    input  logic [2:0]               d_wr_type,
    input  logic [31:0]              d_wr_addr,
    input  logic [3:0]               d_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] d_wr_data,
    output logic                     d_wr_rdy,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);

    logic        ar_pending_q, ar_pending_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        i_busy_q, i_busy_d, d_busy_q, d_busy_d;
    logic        ar_blocked, haz_i, haz_d, i_done, d_done, i_acc, d_acc;
    wstate_e     wstate;
    logic [27:0] wr_line;

    assign rready      = 1'b1;
    assign arvalid     = ar_pending_q;
    assign arid        = arid_q;
    assign araddr      = araddr_q;
    assign arlen       = arlen_q;
    assign arsize      = arsize_q;
    assign awid        = ID_DATA;

    // Beats whose ID has no read in flight (e.g. tail of a burst cut by reset) are consumed and dropped.
    assign i_ret_valid = rvalid && (rid == ID_INST) && i_busy_q;
    assign d_ret_valid = rvalid && (rid == ID_DATA) && d_busy_q;
    assign i_ret_last  = rlast;
    assign d_ret_last  = rlast;
    assign i_ret_data  = rdata;
    assign d_ret_data  = rdata;
    assign i_done      = i_ret_valid && rlast;
    assign d_done      = d_ret_valid && rlast;

    // The AR slot frees in its handshake cycle, and a read's last beat frees its cache, so both allow back-to-back accepts.
    assign ar_blocked  = ar_pending_q && !arready;
    assign haz_i       = (wstate != W_IDLE) && (i_rd_addr[31:4] == wr_line);
    assign haz_d       = (wstate != W_IDLE) && (d_rd_addr[31:4] == wr_line);
    assign d_rd_rdy    = !ar_blocked && !(d_busy_q && !d_done) && !haz_d;
    assign i_rd_rdy    = !ar_blocked && !(i_busy_q && !i_done) && !haz_i && !d_rd_req;
    assign d_acc       = d_rd_req && d_rd_rdy;
    assign i_acc       = i_rd_req && i_rd_rdy;

    always_comb begin
        ar_pending_d = ar_pending_q && !arready;
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        if (d_acc) begin
            ar_pending_d = 1'b1;
            arid_d       = ID_DATA;
            araddr_d     = axi_addr(d_rd_type, d_rd_addr);
            arlen_d      = axi_len(d_rd_type, LINE_WORDS);
            arsize_d     = axi_size(d_rd_type);
        end else if (i_acc) begin
            ar_pending_d = 1'b1;
            arid_d       = ID_INST;
            araddr_d     = axi_addr(i_rd_type, i_rd_addr);
            arlen_d      = axi_len(i_rd_type, LINE_WORDS);
            arsize_d     = axi_size(i_rd_type);
        end
        i_busy_d = (i_busy_q && !i_done) || i_acc;
        d_busy_d = (d_busy_q && !d_done) || d_acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_pending_q <= 1'b0;
            i_busy_q     <= 1'b0;
            d_busy_q     <= 1'b0;
        end else begin
            ar_pending_q <= ar_pending_d;
            i_busy_q     <= i_busy_d;
            d_busy_q     <= d_busy_d;
        end
    end

    always_ff @(posedge clk) begin
        arid_q   <= arid_d;
        araddr_q <= araddr_d;
        arlen_q  <= arlen_d;
        arsize_q <= arsize_d;
    end

    cache_axi_arbiter_wr #(
        .LINE_WORDS (LINE_WORDS)
    ) u_axi_wr_ctrl (
        .clk        (clk),
        .reset      (reset),
        .wr_req_i   (d_wr_req),
        .wr_type_i  (d_wr_type),
        .wr_addr_i  (d_wr_addr),
        .wr_wstrb_i (d_wr_wstrb),
        .wr_data_i  (d_wr_data),
        .wr_rdy_o   (d_wr_rdy),
        .awaddr_o   (awaddr),
        .awlen_o    (awlen),
        .awsize_o   (awsize),
        .awvalid_o  (awvalid),
        .awready_i  (awready),
        .wdata_o    (wdata),
        .wstrb_o    (wstrb),
        .wlast_o    (wlast),
        .wvalid_o   (wvalid),
        .wready_i   (wready),
        .bvalid_i   (bvalid),
        .bready_o   (bready),
        .wstate_o   (wstate),
        .wr_line_o  (wr_line)
    );

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed, table-driven bench for cache_axi_arbiter.
module tb_cache_axi_arbiter;
    import cache_axi_arbiter_pkg::*;

    logic         clk, reset;
    logic         i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr, i_ret_data;
    logic         d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr, d_ret_data;
    logic         d_wr_req, d_wr_rdy;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic [3:0]   arid, rid, awid, wstrb;
    logic [31:0]  araddr, rdata, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  rid;
        logic [31:0] data;
        logic        last;
        logic        exp_i;
        logic        exp_d;
    } beat_t;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic [2:0]  exp_size;
    } rd_vec_t;

    beat_t   beats [9];
    rd_vec_t rvecs [4];
    logic [31:0] wr_words [4];

    cache_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
        .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic d_read(input rd_vec_t v);
        d_rd_req = 1'b1; d_rd_type = v.typ; d_rd_addr = v.addr;
        #1;
        check("d_rd_rdy idle", 128'(d_rd_rdy), 128'(1'b1));
        step();
        d_rd_req = 1'b0; arready = 1'b1;
        #1;
        check("sz arvalid", 128'(arvalid), 128'(1'b1));
        check("sz arid", 128'(arid), 128'(4'd1));
        check("sz araddr", 128'(araddr), 128'(v.exp_addr));
        check("sz arlen", 128'(arlen), 128'(v.exp_len));
        check("sz arsize", 128'(arsize), 128'(v.exp_size));
        step();
        arready = 1'b0;
        for (int b = 0; b <= int'(v.exp_len); b++) begin
            rvalid = 1'b1; rid = 4'd1; rdata = 32'hd000_0000 + b; rlast = (b == int'(v.exp_len));
            #1;
            check("sz d_ret_valid", 128'(d_ret_valid), 128'(1'b1));
            check("sz d_ret_last", 128'(d_ret_last), 128'(b == int'(v.exp_len)));
            // Busy until the last beat, which itself frees the DCache read slot.
            check("sz d_rd_rdy in burst", 128'(d_rd_rdy), 128'(b == int'(v.exp_len)));
            step();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        check("sz d_busy cleared", 128'(d_rd_rdy), 128'(1'b1));
        check("sz arvalid idle", 128'(arvalid), 128'(1'b0));
    endtask

    task automatic wr_accept(input logic [31:0] a, input logic [127:0] data);
        d_wr_req = 1'b1; d_wr_type = RD_TYPE_LINE; d_wr_addr = a; d_wr_data = data; d_wr_wstrb = 4'h0;
        #1;
        check("d_wr_rdy idle", 128'(d_wr_rdy), 128'(1'b1));
        step();
        d_wr_req = 1'b0;
    endtask

    initial begin
        beats[0] = '{4'd1, 32'hd000_0001, 1'b0, 1'b0, 1'b1};
        beats[1] = '{4'd0, 32'h1000_0001, 1'b0, 1'b1, 1'b0};
        beats[2] = '{4'd1, 32'hd000_0002, 1'b0, 1'b0, 1'b1};
        beats[3] = '{4'd0, 32'h1000_0002, 1'b0, 1'b1, 1'b0};
        beats[4] = '{4'd1, 32'hd000_0003, 1'b0, 1'b0, 1'b1};
        beats[5] = '{4'd1, 32'hd000_0004, 1'b1, 1'b0, 1'b1};
        beats[6] = '{4'd0, 32'h1000_0003, 1'b0, 1'b1, 1'b0};
        beats[7] = '{4'd0, 32'h1000_0004, 1'b1, 1'b1, 1'b0};
        beats[8] = '{4'd1, 32'hdead_beef, 1'b1, 1'b0, 1'b0};
        rvecs[0] = '{RD_TYPE_WORD, 32'hbfaf_8000, 32'hbfaf_8000, 8'd0, 3'd2};
        rvecs[1] = '{RD_TYPE_BYTE, 32'h0000_0013, 32'h0000_0013, 8'd0, 3'd0};
        rvecs[2] = '{RD_TYPE_HALF, 32'h0000_0122, 32'h0000_0122, 8'd0, 3'd1};
        rvecs[3] = '{RD_TYPE_LINE, 32'h0000_123c, 32'h0000_1230, 8'd3, 3'd2};
        wr_words[0] = 32'h1111; wr_words[1] = 32'h2222; wr_words[2] = 32'h3333; wr_words[3] = 32'h4444;

        reset = 1'b1;
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
        arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0;
        step(); step();
        check("rst arvalid", 128'(arvalid), 128'(1'b0));
        check("rst awvalid", 128'(awvalid), 128'(1'b0));
        check("rst wvalid", 128'(wvalid), 128'(1'b0));
        check("rst bready", 128'(bready), 128'(1'b0));
        check("rst d_wr_rdy", 128'(d_wr_rdy), 128'(1'b1));
        check("rst rready", 128'(rready), 128'(1'b1));
        reset = 1'b0;
        #1;
        check("rst i_rd_rdy", 128'(i_rd_rdy), 128'(1'b1));

        // Simultaneous line reads: DCache first, ICache the following cycle.
        i_rd_req = 1; i_rd_type = RD_TYPE_LINE; i_rd_addr = 32'h1c00_0000;
        d_rd_req = 1; d_rd_type = RD_TYPE_LINE; d_rd_addr = 32'h0000_1000;
        #1;
        check("arb d_rd_rdy", 128'(d_rd_rdy), 128'(1'b1));
        check("arb i_rd_rdy blocked", 128'(i_rd_rdy), 128'(1'b0));
        step();
        d_rd_req = 0; arready = 1;
        #1;
        check("ar1 arvalid", 128'(arvalid), 128'(1'b1));
        check("ar1 arid", 128'(arid), 128'(4'd1));
        check("ar1 araddr", 128'(araddr), 128'(32'h0000_1000));
        check("ar1 arlen", 128'(arlen), 128'(8'd3));
        check("ar1 i_rd_rdy", 128'(i_rd_rdy), 128'(1'b1));
        step();
        i_rd_req = 0;
        #1;
        check("ar2 arvalid", 128'(arvalid), 128'(1'b1));
        check("ar2 arid", 128'(arid), 128'(4'd0));
        check("ar2 araddr", 128'(araddr), 128'(32'h1c00_0000));
        check("ar2 arlen", 128'(arlen), 128'(8'd3));
        step();
        arready = 0;
        #1;
        check("ar idle", 128'(arvalid), 128'(1'b0));
        for (int k = 0; k < 9; k++) begin
            rvalid = 1; rid = beats[k].rid; rdata = beats[k].data; rlast = beats[k].last;
            #1;
            check($sformatf("beat%0d i_ret_valid", k), 128'(i_ret_valid), 128'(beats[k].exp_i));
            check($sformatf("beat%0d d_ret_valid", k), 128'(d_ret_valid), 128'(beats[k].exp_d));
            if (beats[k].exp_i) begin
                check($sformatf("beat%0d i_ret_data", k), 128'(i_ret_data), 128'(beats[k].data));
                check($sformatf("beat%0d i_ret_last", k), 128'(i_ret_last), 128'(beats[k].last));
            end
            if (beats[k].exp_d) begin
                check($sformatf("beat%0d d_ret_data", k), 128'(d_ret_data), 128'(beats[k].data));
                check($sformatf("beat%0d d_ret_last", k), 128'(d_ret_last), 128'(beats[k].last));
            end
            step();
        end
        rvalid = 0; rlast = 0;
        #1;
        check("i_busy cleared", 128'(i_rd_rdy), 128'(1'b1));
        check("d_busy cleared", 128'(d_rd_rdy), 128'(1'b1));

        // Read sizing per request type.
        for (int k = 0; k < 4; k++) d_read(rvecs[k]);

        // Line write with AW and W ready.
        wr_accept(32'h0000_2000, {32'h4444, 32'h3333, 32'h2222, 32'h1111});
        awready = 1; wready = 1;
        for (int b = 0; b < 4; b++) begin
            #1;
            check("wr awvalid", 128'(awvalid), 128'(b == 0));
            check("wr wvalid", 128'(wvalid), 128'(1'b1));
            check("wr wdata", 128'(wdata), 128'(wr_words[b]));
            check("wr wlast", 128'(wlast), 128'(b == 3));
            check("wr wstrb", 128'(wstrb), 128'(4'hf));
            if (b == 0) begin
                check("wr awlen", 128'(awlen), 128'(8'd3));
                check("wr awaddr", 128'(awaddr), 128'(32'h0000_2000));
                check("wr awid", 128'(awid), 128'(4'd1));
                check("wr d_wr_rdy busy", 128'(d_wr_rdy), 128'(1'b0));
            end
            step();
        end
        awready = 0; wready = 0;
        #1;
        check("wr resp wvalid", 128'(wvalid), 128'(1'b0));
        check("wr resp bready", 128'(bready), 128'(1'b1));
        step();
        bvalid = 1;
        #1;
        check("wr bready held", 128'(bready), 128'(1'b1));
        check("wr d_wr_rdy in resp", 128'(d_wr_rdy), 128'(1'b0));
        step();
        bvalid = 0;
        #1;
        check("wr d_wr_rdy back", 128'(d_wr_rdy), 128'(1'b1));
        check("wr bready done", 128'(bready), 128'(1'b0));

        // W completes before a late awready.
        wr_accept(32'h0000_5000, {32'h8888, 32'h7777, 32'h6666, 32'h5555});
        wready = 1;
        for (int b = 0; b < 4; b++) begin
            #1;
            check("late aw awvalid", 128'(awvalid), 128'(1'b1));
            check("late aw wdata", 128'(wdata), 128'(32'h5555 + 32'h1111 * b));
            step();
        end
        wready = 0;
        for (int b = 0; b < 2; b++) begin
            #1;
            check("late aw wvalid done", 128'(wvalid), 128'(1'b0));
            check("late aw still waiting", 128'(awvalid), 128'(1'b1));
            check("late aw no bready", 128'(bready), 128'(1'b0));
            step();
        end
        awready = 1;
        step();
        awready = 0;
        #1;
        check("late aw bready", 128'(bready), 128'(1'b1));
        check("late aw awvalid off", 128'(awvalid), 128'(1'b0));
        bvalid = 1;
        step();
        bvalid = 0;
        #1;
        check("late aw d_wr_rdy", 128'(d_wr_rdy), 128'(1'b1));

        // Read hazard against a pending write line.
        wr_accept(32'h0000_2000, {32'h4444, 32'h3333, 32'h2222, 32'h1111});
        d_rd_req = 1; d_rd_type = RD_TYPE_WORD; d_rd_addr = 32'h0000_2008;
        #1;
        check("haz d same line", 128'(d_rd_rdy), 128'(1'b0));
        d_rd_addr = 32'h0000_3000;
        #1;
        check("haz d other line", 128'(d_rd_rdy), 128'(1'b1));
        step();
        d_rd_req = 0; arready = 1;
        #1;
        check("haz other araddr", 128'(araddr), 128'(32'h0000_3000));
        step();
        arready = 0; rvalid = 1; rid = 4'd1; rlast = 1; rdata = 32'h3;
        #1;
        check("haz other ret", 128'(d_ret_valid), 128'(1'b1));
        step();
        rvalid = 0; rlast = 0;
        i_rd_req = 1; i_rd_type = RD_TYPE_WORD; i_rd_addr = 32'h0000_200c;
        #1;
        check("haz i same line", 128'(i_rd_rdy), 128'(1'b0));
        i_rd_req = 0;
        awready = 1; wready = 1;
        for (int b = 0; b < 4; b++) step();
        awready = 0; wready = 0;
        d_rd_req = 1; d_rd_addr = 32'h0000_2008;
        #1;
        check("haz held in resp", 128'(d_rd_rdy), 128'(1'b0));
        bvalid = 1;
        step();
        bvalid = 0;
        #1;
        check("haz released", 128'(d_rd_rdy), 128'(1'b1));
        d_rd_req = 0;

        // Reset in the middle of a burst with another AR outstanding.
        d_rd_req = 1; d_rd_type = RD_TYPE_LINE; d_rd_addr = 32'h0000_4000;
        step();
        d_rd_req = 0; arready = 1;
        i_rd_req = 1; i_rd_type = RD_TYPE_LINE; i_rd_addr = 32'h1c00_0040;
        step();
        i_rd_req = 0; arready = 0;
        for (int b = 0; b < 2; b++) begin
            rvalid = 1; rid = 4'd1; rlast = 0; rdata = 32'h40 + b;
            #1;
            check("rst6 pre beat", 128'(d_ret_valid), 128'(1'b1));
            step();
        end
        rvalid = 0;
        #1;
        check("rst6 arvalid pre", 128'(arvalid), 128'(1'b1));
        reset = 1;
        step();
        reset = 0;
        #1;
        check("rst6 arvalid", 128'(arvalid), 128'(1'b0));
        check("rst6 d_busy", 128'(d_rd_rdy), 128'(1'b1));
        check("rst6 i_busy", 128'(i_rd_rdy), 128'(1'b1));
        for (int b = 0; b < 2; b++) begin
            rvalid = 1; rid = 4'd1; rlast = (b == 1); rdata = 32'h42 + b;
            #1;
            check("rst6 dropped beat", 128'(d_ret_valid), 128'(1'b0));
            check("rst6 no i beat", 128'(i_ret_valid), 128'(1'b0));
            step();
        end
        rvalid = 0; rlast = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
